ctx_save_restore: RTL
=====================

CTX_SAVE_RESTORE -- requirements
Module: ctx_save_restore

Interface
REQ-001 The block SHALL have parameter ZERO_REG, default 4'd1: index of the hardwired-zero register, never transferred.
REQ-002 The block SHALL have parameter NUM_REGS, default 16: number of register-file entries walked (indices 0..NUM_REGS-1).
REQ-003 The block SHALL have port clk, input, 1: clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1: begin operation; sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1: 0 = save (register file to memory), 1 = restore (memory to register file); sampled with start.
REQ-007 The block SHALL have port base_addr, input, 16: memory base address; sampled with start.
REQ-008 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 The block SHALL have port rf_read_reg, output, 4: register-file read index.
REQ-011 The block SHALL have port rf_read_data, input, 16: combinational register-file read data for rf_read_reg.
REQ-012 The block SHALL have ports rf_write_reg (output, 4), rf_write_data (output, 16) and rf_reg_write (output, 1): register-file write port.
REQ-013 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 16) and mem_wdata (output, 16): memory request.
REQ-014 The block SHALL have ports mem_ack (input, 1) and mem_rdata (input, 16): memory response; mem_rdata is valid in the ack cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, SAVE, LOAD, WB and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch mode and base_addr, set idx to the first index not equal to ZERO_REG, and go to SAVE (mode=0) or LOAD (mode=1).
REQ-017 The index sequence SHALL be ascending, SHALL skip ZERO_REG with zero cycle cost, and SHALL end after NUM_REGS-1.
REQ-018 In SAVE, the outputs SHALL be: mem_req=1, mem_we=1, mem_addr=base+idx, rf_read_reg=idx, mem_wdata=rf_read_data (combinational).
REQ-019 A memory transfer SHALL complete on a rising edge where mem_req=1 and mem_ack=1; request outputs SHALL stay stable until then.
REQ-020 On SAVE completion, the block SHALL advance idx and stay in SAVE, or go to DONE if idx was the last index.
REQ-021 In LOAD, the outputs SHALL be: mem_req=1, mem_we=0, mem_addr=base+idx. On completion, the block SHALL capture mem_rdata and go to WB.
REQ-022 WB SHALL last exactly one cycle with rf_reg_write=1, rf_write_reg=idx and rf_write_data=captured data, then advance idx to LOAD, or go to DONE after the last index.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Address arithmetic SHALL be modulo 2^16; base+idx wraps past 16'hFFFF.
REQ-025 start SHALL be ignored while busy=1; a start held high through DONE SHALL not be sampled until IDLE.
REQ-026 mem_ack asserted while mem_req=0 SHALL be ignored.
REQ-027 rf_reg_write SHALL never assert in SAVE, and SHALL never assert with rf_write_reg=ZERO_REG.
REQ-028 When not in SAVE, LOAD or WB, the outputs SHALL be: mem_req=0, mem_we=0, rf_reg_write=0, and addresses/data 0.
REQ-029 Latency with mem_ack tied high SHALL be: save = start edge + 15 SAVE cycles, then done; restore = 30 cycles (15 x LOAD+WB), then done.
REQ-030 The external core SHALL hold off its own register-file writes while busy=1; the block does not arbitrate.

Reset
REQ-031 While reset=1, the block SHALL go to IDLE immediately (asynchronously) and clear idx, the latched mode/base and the captured data.
REQ-032 On reset, all outputs SHALL be 0: busy, done, mem_req, mem_we, rf_reg_write, and all address and data buses.
REQ-033 Reset mid-operation SHALL abort without a done pulse; a pending memory request SHALL drop immediately; no further register write SHALL occur.

Verification
REQ-034 Save, base=16'h0100, ack tied high, r[i]=16'hA000+i -> 15 writes to 0x0100..0x010F excluding 0x0101, data A000+i; done in cycle 16 after start.
REQ-035 Restore, base=16'h0200, memory[0x0200+i]=16'h5A00+i, ack delayed 2 cycles per request -> 15 writes r[i]=5A00+i, no write to index 1; request outputs stable during wait.
REQ-036 Save with base=16'hFFF8 -> addresses FFF8..FFFF then 0000..0007 (index 1 = FFF9 skipped).
REQ-037 start pulsed repeatedly during save, and spurious mem_ack while IDLE -> single operation, no extra transfers, busy only during the operation.
REQ-038 reset asserted in LOAD with mem_req high -> mem_req/busy low before the next edge, done never pulses, next start restarts at idx 0.

Source files
------------

// File: rtl/ctx_save_restore.sv
// ctx_save_restore
// Walks the register file in ascending index order and either saves every
// entry to memory (mode=0) or restores every entry from memory (mode=1).
// The hardwired-zero register is skipped at no cycle cost. Memory transfers
// use a req/ack handshake, and the request is held stable until it is acknowledged.
// Outputs are decoded from registered state only. The single exception is
// mem_wdata, which forwards the combinational register-file read data.

module ctx_save_restore #(
   parameter logic [3:0] ZERO_REG = 4'd1,
   parameter int         NUM_REGS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] base_addr,
   output logic        busy,
   output logic        done,
   output logic [3:0]  rf_read_reg,
   input  logic [15:0] rf_read_data,
   output logic [3:0]  rf_write_reg,
   output logic [15:0] rf_write_data,
   output logic        rf_reg_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
);

   // ------------------------------------------------------------------
   // Index range. The walk runs from the first index that is not the zero
   // register up to the last index that is not the zero register.
   // ------------------------------------------------------------------
   localparam logic [4:0] LAST_RAW  = 5'(NUM_REGS - 1);
   localparam logic [4:0] LAST_SKIP = (LAST_RAW == {1'b0, ZERO_REG}) ?
                                      (LAST_RAW - 5'd1) : LAST_RAW;
   localparam logic [3:0] LAST_IDX  = LAST_SKIP[3:0];
   localparam logic [3:0] FIRST_IDX = (ZERO_REG == 4'd0) ? 4'd1 : 4'd0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SAVE = 3'd1,
      LOAD = 3'd2,
      WB   = 3'd3,
      DONE = 3'd4
   } state_t;

   // Next index in the walk, stepping over the zero register.
   function automatic logic [3:0] next_idx(input logic [3:0] cur);
      logic [3:0] n;
      n = cur + 4'd1;
      if (n == ZERO_REG) begin
         n = n + 4'd1;
      end else begin
         n = n;
      end
      return n;
   endfunction

   // Memory address for an index. It wraps modulo 2^16.
   function automatic logic [15:0] addr_of(input logic [15:0] base,
                                           input logic [3:0]  idx);
      return base + {12'd0, idx};
   endfunction

   state_t      state_r, state_s;
   logic [3:0]  idx_r,   idx_s;
   logic        mode_r,  mode_s;
   logic [15:0] base_r,  base_s;
   logic [15:0] data_r,  data_s;
   logic        last_s;

   assign last_s = (idx_r == LAST_IDX);

   // State and datapath registers. Reset aborts at once and clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         idx_r   <= 4'd0;
         mode_r  <= 1'b0;
         base_r  <= 16'd0;
         data_r  <= 16'd0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         mode_r  <= mode_s;
         base_r  <= base_s;
         data_r  <= data_s;
      end
   end

   // Next-state logic. mem_ack is only examined in SAVE and LOAD, the only
   // states that raise mem_req, so a stray ack in any other state has no effect.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      mode_s  = mode_r;
      base_s  = base_r;
      data_s  = data_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               mode_s  = mode;
               base_s  = base_addr;
               idx_s   = FIRST_IDX;
               state_s = mode ? LOAD : SAVE;
            end else begin
               state_s = IDLE;
            end
         end
         SAVE: begin
            if (mem_ack) begin
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  idx_s   = next_idx(idx_r);
                  state_s = SAVE;
               end
            end else begin
               state_s = SAVE;
            end
         end
         LOAD: begin
            if (mem_ack) begin
               data_s  = mem_rdata;
               state_s = WB;
            end else begin
               state_s = LOAD;
            end
         end
         WB: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               idx_s   = next_idx(idx_r);
               state_s = LOAD;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode. Every output is zero outside the active states, and
   // rf_reg_write is additionally gated so the zero register is never written.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      rf_read_reg   = 4'd0;
      rf_write_reg  = 4'd0;
      rf_write_data = 16'd0;
      rf_reg_write  = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = 16'd0;
      mem_wdata     = 16'd0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
         end
         SAVE: begin
            busy        = 1'b1;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = addr_of(base_r, idx_r);
            rf_read_reg = idx_r;
            mem_wdata   = rf_read_data;
         end
         LOAD: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_addr = addr_of(base_r, idx_r);
         end
         WB: begin
            busy          = 1'b1;
            rf_reg_write  = mode_r && (idx_r != ZERO_REG);
            rf_write_reg  = idx_r;
            rf_write_data = data_r;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
